ring_buffer: RTL and testbench

Parameterised single-clock circular FIFO that stores fixed-width data words in an internal memory of 2^BITLENGTH entries. It provides registered read data with a one-cycle acknowledge, refuses writes when full and reads when empty, and exposes its occupancy and pointer values for status and debug. It sits between a producer and a consumer in the same clock domain, for example a byte stream feeding a processor or peripheral.

---
 rtl/ring_buffer.sv | 86 ++++++++
 tb/tb_ring_buffer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/ring_buffer.sv
// ring_buffer: single-clock circular FIFO of 2^BITLENGTH words, WIDTH bits each.
// One slot is always left empty, so usable capacity is 2^BITLENGTH - 1.
//
// Ports:
//   clk          - clock, all state changes on the rising edge
//   reset        - asynchronous, active-low reset
//   writeEnable  - write request; accepted only when not full
//   data         - word to write
//   readEnable   - read request; accepted only when not empty
//   dataReadAck  - registered, high for the cycle after an accepted read
//   dataRead     - registered data of the last accepted read (holds otherwise)
//   bufferLength - occupancy, zero-extended to 32 bits
//   debug        - read pointer, zero-extended to 32 bits
//   debug2       - write pointer, zero-extended to 32 bits
module ring_buffer #(
   parameter int WIDTH     = 8,
   parameter int BITLENGTH = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             writeEnable,
   input  logic [WIDTH-1:0] data,
   input  logic             readEnable,
   output logic             dataReadAck,
   output logic [WIDTH-1:0] dataRead,
   output logic [31:0]      bufferLength,
   output logic [31:0]      debug,
   output logic [31:0]      debug2
);

   localparam int DEPTH = 1 << BITLENGTH;

   // Storage is never reset; only the pointers define what is valid.
   logic [WIDTH-1:0]     mem [DEPTH];

   logic [BITLENGTH-1:0] rptr;
   logic [BITLENGTH-1:0] wptr;
   logic [BITLENGTH-1:0] rptr_inc;
   logic [BITLENGTH-1:0] wptr_inc;
   logic [BITLENGTH-1:0] occupancy;
   logic                 empty;
   logic                 full;
   logic                 wr_ok;
   logic                 rd_ok;

   assign rptr_inc  = rptr + BITLENGTH'(1);
   assign wptr_inc  = wptr + BITLENGTH'(1);
   assign occupancy = wptr - rptr;

   assign empty = (rptr == wptr);
   assign full  = (wptr_inc == rptr);

   // Both requests are judged against the pre-edge state, so a read when
   // full and a write when empty never depend on each other.
   assign wr_ok = writeEnable && !full;
   assign rd_ok = readEnable && !empty;

   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[wptr] <= data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rptr        <= '0;
         wptr        <= '0;
         dataReadAck <= 1'b0;
         dataRead    <= '0;
      end else begin
         if (wr_ok) begin
            wptr <= wptr_inc;
         end
         if (rd_ok) begin
            rptr     <= rptr_inc;
            dataRead <= mem[rptr];
         end
         dataReadAck <= rd_ok;
      end
   end

   assign bufferLength = 32'(occupancy);
   assign debug        = 32'(rptr);
   assign debug2       = 32'(wptr);

endmodule

// File: tb/tb_ring_buffer.sv
module tb_ring_buffer;

   logic        clk;
   logic        reset;
   logic        writeEnable;
   logic [7:0]  data;
   logic        readEnable;
   logic        dataReadAck;
   logic [7:0]  dataRead;
   logic [31:0] bufferLength;
   logic [31:0] debug;
   logic [31:0] debug2;

   ring_buffer #(.WIDTH(8), .BITLENGTH(2)) dut (
      .clk          (clk),
      .reset        (reset),
      .writeEnable  (writeEnable),
      .data         (data),
      .readEnable   (readEnable),
      .dataReadAck  (dataReadAck),
      .dataRead     (dataRead),
      .bufferLength (bufferLength),
      .debug        (debug),
      .debug2       (debug2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model: contents as a queue, pointers as plain counters mod 4.
   logic [7:0] mq [$];
   int         m_rptr;
   int         m_wptr;
   logic       m_ack;
   logic [7:0] m_data;

   int checks;
   int errors;
   bit chk_en;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_rptr = 0;
      m_wptr = 0;
      m_ack  = 1'b0;
      m_data = 8'h00;
   endtask

   // One clock transaction; the model is updated from its pre-edge state.
   task automatic cyc(input bit we, input logic [7:0] d, input bit re);
      bit full_pre;
      bit empty_pre;
      writeEnable = we;
      data        = d;
      readEnable  = re;
      @(posedge clk);
      full_pre  = (mq.size() == 3);
      empty_pre = (mq.size() == 0);
      m_ack = re && !empty_pre;
      if (m_ack) begin
         m_data = mq.pop_front();
         m_rptr = (m_rptr + 1) % 4;
      end
      if (we && !full_pre) begin
         mq.push_back(d);
         m_wptr = (m_wptr + 1) % 4;
      end
      #1;
      $display("txn we=%0d d=%02h re=%0d -> ack=%0d rd=%02h len=%0d r=%0d w=%0d",
               we, d, re, dataReadAck, dataRead, bufferLength, debug, debug2);
   endtask

   // Cycle-by-cycle comparison against the model, on the falling edge.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("len",  bufferLength, 32'(mq.size()));
         chk("rptr", debug,        32'(m_rptr));
         chk("wptr", debug2,       32'(m_wptr));
         chk("ack",  {31'b0, dataReadAck}, {31'b0, m_ack});
         chk("data", {24'b0, dataRead},    {24'b0, m_data});
      end
   end

   task automatic check_all_zero(input string tag);
      chk({tag, "_len"},  bufferLength, 32'd0);
      chk({tag, "_rptr"}, debug,        32'd0);
      chk({tag, "_wptr"}, debug2,       32'd0);
      chk({tag, "_ack"},  {31'b0, dataReadAck}, 32'd0);
      chk({tag, "_data"}, {24'b0, dataRead},    32'd0);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      chk_en = 1'b0;
      reset = 1'b0;
      writeEnable = 1'b0;
      readEnable = 1'b0;
      data = 8'h00;
      model_reset();
      #2;
      check_all_zero("por");
      @(negedge clk);
      #2;
      reset = 1'b1;
      chk_en = 1'b1;

      // Fill and overflow
      cyc(1, 8'h01, 0); chk("fill1_len", bufferLength, 32'd1);
      cyc(1, 8'h02, 0); chk("fill2_len", bufferLength, 32'd2);
      cyc(1, 8'h03, 0); chk("fill3_len", bufferLength, 32'd3);
      cyc(1, 8'h04, 0); chk("ovf_len", bufferLength, 32'd3);
      chk("ovf_wptr", debug2, 32'd3);

      // Drain and underflow
      cyc(0, 8'h00, 1); chk("dr1_data", {24'b0, dataRead}, 32'h01); chk("dr1_len", bufferLength, 32'd2);
      cyc(0, 8'h00, 1); chk("dr2_data", {24'b0, dataRead}, 32'h02); chk("dr2_len", bufferLength, 32'd1);
      cyc(0, 8'h00, 1); chk("dr3_data", {24'b0, dataRead}, 32'h03); chk("dr3_ack", {31'b0, dataReadAck}, 32'd1);
      cyc(0, 8'h00, 1); chk("udf_ack", {31'b0, dataReadAck}, 32'd0);
      chk("udf_data", {24'b0, dataRead}, 32'h03); chk("udf_len", bufferLength, 32'd0);

      // Wrap-around
      cyc(1, 8'h02, 0); cyc(1, 8'h03, 0); cyc(1, 8'h04, 0);
      cyc(0, 8'h00, 1); chk("wr_rd1", {24'b0, dataRead}, 32'h02);
      cyc(0, 8'h00, 1); chk("wr_rd2", {24'b0, dataRead}, 32'h03);
      cyc(1, 8'h07, 0); cyc(1, 8'h08, 0);
      chk("wr_len3", bufferLength, 32'd3); chk("wr_wptr0", debug2, 32'd0);
      cyc(1, 8'h09, 0); chk("wr_drop_len", bufferLength, 32'd3);
      cyc(0, 8'h00, 1); chk("wr_rd3", {24'b0, dataRead}, 32'h04);
      cyc(0, 8'h00, 1); chk("wr_rd4", {24'b0, dataRead}, 32'h07);
      cyc(0, 8'h00, 1); chk("wr_rd5", {24'b0, dataRead}, 32'h08);
      chk("wr_rptr0", debug, 32'd0);

      // Simultaneous access
      cyc(1, 8'h11, 0);
      cyc(1, 8'h22, 1); chk("sim_data", {24'b0, dataRead}, 32'h11); chk("sim_len", bufferLength, 32'd1);
      cyc(0, 8'h00, 1); chk("sim_next", {24'b0, dataRead}, 32'h22);
      cyc(1, 8'h33, 1); chk("sim_empty_ack", {31'b0, dataReadAck}, 32'd0);
      chk("sim_empty_len", bufferLength, 32'd1);
      cyc(1, 8'h44, 0); cyc(1, 8'h55, 0);
      cyc(1, 8'h66, 1); chk("sim_full_data", {24'b0, dataRead}, 32'h33);
      chk("sim_full_len", bufferLength, 32'd2);

      // Idle
      for (int i = 0; i < 10; i++) begin
         cyc(0, 8'h00, 0);
      end
      chk("idle_ack", {31'b0, dataReadAck}, 32'd0);
      chk("idle_len", bufferLength, 32'd2);
      chk("idle_data", {24'b0, dataRead}, 32'h33);

      // Randomised traffic
      for (int i = 0; i < 300; i++) begin
         cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
      end

      // Ensure something is stored, then reset asynchronously mid-stream
      cyc(1, 8'hA5, 0);
      cyc(1, 8'h5A, 1);
      chk_en = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      check_all_zero("arst");
      model_reset();
      @(negedge clk);
      #2;
      reset = 1'b1;
      chk_en = 1'b1;
      cyc(0, 8'h00, 1);
      chk("post_rst_len", bufferLength, 32'd0);
      chk("post_rst_ack", {31'b0, dataReadAck}, 32'd0);

      for (int i = 0; i < 100; i++) begin
         cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
      end

      @(negedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
